manycore_dram_addr_hash: RTL and testbench

Registered DRAM address hash for the manycore mesh. It maps a 32-bit DRAM EVA (bit 31 set) to a network physical address: global x/y cord of the owning vcache plus an EPA word address. DRAM is striped across all vcaches at cache-line granularity. Striping starts at the north vcaches and alternates north/south, moving from inner vcache layers to outer layers. It feeds the EVA-to-NPA translator in each endpoint.

---
 rtl/manycore_dram_addr_hash.sv | 137 +++++++++++++
 tb/tb_manycore_dram_addr_hash.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/manycore_dram_addr_hash.sv
`default_nettype none
//============================================================================
// Module      : manycore_dram_addr_hash
// Description : Registered DRAM EVA -> NPA hash for the manycore mesh.
//               Stripes DRAM across all vcaches at cache-line granularity,
//               alternating north/south pods and walking from the inner
//               vcache layer outward. One cycle of latency, no backpressure.
// Option      : define MANYCORE_DRAM_HASH_CHECK_EN to compile simulation-only
//               checks (non-DRAM EVA, x cord width consistency).
// Revision    : 1.0 - initial release
//============================================================================
module manycore_dram_addr_hash #(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int pod_x_cord_width_p           = 3,
  parameter int pod_y_cord_width_p           = 4,
  parameter int x_subcord_width_p            = 4,
  parameter int y_subcord_width_p            = 3,
  parameter int num_vcache_rows_p            = 1,
  parameter int vcache_block_size_in_words_p = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  input  logic [data_width_p-1:0]       eva_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  output logic                          v_o,
  output logic [x_cord_width_p-1:0]     x_cord_o,
  output logic [y_cord_width_p-1:0]     y_cord_o,
  output logic [addr_width_p-1:0]       epa_o
);

  // Word-offset width inside a line; a one-word line still keeps one bit.
  localparam int c_w = (vcache_block_size_in_words_p > 1) ?
                       $clog2(vcache_block_size_in_words_p) : 1;
  // Row-select width: north/south times the number of vcache layers.
  localparam int c_r          = $clog2(2 * num_vcache_rows_p);
  // Block index spans eva[30 : 2+W]; bit 31 (DRAM marker) is not hashed.
  localparam int c_bw         = data_width_p - 3 - c_w;
  localparam int c_bank_w     = x_subcord_width_p + c_r;
  localparam int c_epa_full_w = c_bw - c_bank_w + c_w;

  logic [c_bw-1:0]               block;
  logic [c_bank_w-1:0]           bank;
  logic [x_subcord_width_p-1:0]  x_sub;
  logic [c_r-1:0]                row;
  logic [y_subcord_width_p-1:0]  layer;
  logic [y_subcord_width_p-1:0]  y_sub;
  logic [pod_y_cord_width_p-1:0] y_pod;
  logic [c_epa_full_w-1:0]       epa_full;
  logic [addr_width_p-1:0]       epa_fit;
  logic                          unused_bits;

  assign block    = eva_i[data_width_p-2 : 2+c_w];
  assign bank     = block[c_bank_w-1:0];
  assign x_sub    = bank[x_subcord_width_p-1:0];
  assign row      = bank[x_subcord_width_p +: c_r];
  assign layer    = y_subcord_width_p'(row >> 1);

  // Even rows go to the north pod (inner layer sits at the bottom, nearest
  // the tiles); odd rows go to the south pod (inner layer at the top).
  assign y_pod    = row[0] ? (pod_y_i + pod_y_cord_width_p'(1))
                           : (pod_y_i - pod_y_cord_width_p'(1));
  assign y_sub    = row[0] ? layer
                           : (y_subcord_width_p'(num_vcache_rows_p - 1) - layer);

  // Line address within the owning vcache, then the word within the line.
  assign epa_full = {block[c_bw-1:c_bank_w], eva_i[2 +: c_w]};

  if (c_epa_full_w >= addr_width_p) begin : g_epa_trunc
    assign epa_fit = epa_full[addr_width_p-1:0];
  end else begin : g_epa_ext
    assign epa_fit = {{(addr_width_p-c_epa_full_w){1'b0}}, epa_full};
  end

  // Byte offset and the DRAM marker bit are intentionally dropped.
  assign unused_bits = ^{eva_i[data_width_p-1], eva_i[1:0], epa_full};

  logic                      v_d,      v_q;
  logic [x_cord_width_p-1:0] x_cord_d, x_cord_q;
  logic [y_cord_width_p-1:0] y_cord_d, y_cord_q;
  logic [addr_width_p-1:0]   epa_d,    epa_q;

  // Next-state: valid follows v_i; the address fields load only on valid.
  always_comb begin
    v_d      = v_i;
    x_cord_d = x_cord_q;
    y_cord_d = y_cord_q;
    epa_d    = epa_q;
    if (v_i) begin
      x_cord_d = {pod_x_i, x_sub};
      y_cord_d = {y_pod, y_sub};
      epa_d    = epa_fit;
    end
  end

  // Output registers with synchronous active-low reset overriding v_i.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q      <= 1'b0;
      x_cord_q <= '0;
      y_cord_q <= '0;
      epa_q    <= '0;
    end else begin
      v_q      <= v_d;
      x_cord_q <= x_cord_d;
      y_cord_q <= y_cord_d;
      epa_q    <= epa_d;
    end
  end

  assign v_o      = v_q;
  assign x_cord_o = x_cord_q;
  assign y_cord_o = y_cord_q;
  assign epa_o    = epa_q;

`ifdef MANYCORE_DRAM_HASH_CHECK_EN
  // Flag non-DRAM addresses; they are still hashed as DRAM.
  always @(posedge clk_i) begin
    if (reset_n_i && v_i && !eva_i[data_width_p-1])
      $error("%0t: non-DRAM EVA hashed: eva_i=%h", $time, eva_i);
  end

  // Global x cord must be exactly pod x plus tile x subcord.
  always @(posedge clk_i) begin
    if (x_cord_width_p != pod_x_cord_width_p + x_subcord_width_p)
      $error("x_cord_width_p (%0d) != pod_x_cord_width_p + x_subcord_width_p (%0d)",
             x_cord_width_p, pod_x_cord_width_p + x_subcord_width_p);
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_manycore_dram_addr_hash.sv
`default_nettype none
//============================================================================
// Module      : tb_manycore_dram_addr_hash
// Description : Self-checking bench for manycore_dram_addr_hash with
//               directed scenarios plus randomized traffic against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_manycore_dram_addr_hash;

  localparam longint c_nx   = 16;   // tiles in x
  localparam longint c_rows = 1;    // vcache rows per pod
  localparam longint c_blk  = 8;    // words per line

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [31:0] eva_i;
  logic [2:0]  pod_x_i;
  logic [3:0]  pod_y_i;
  logic        v_o;
  logic [6:0]  x_cord_o;
  logic [6:0]  y_cord_o;
  logic [27:0] epa_o;

  int checks = 0;
  int errors = 0;

  // Expected registered state
  longint m_v, m_x, m_y, m_epa;

  manycore_dram_addr_hash dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .eva_i     (eva_i),
    .pod_x_i   (pod_x_i),
    .pod_y_i   (pod_y_i),
    .v_o       (v_o),
    .x_cord_o  (x_cord_o),
    .y_cord_o  (y_cord_o),
    .epa_o     (epa_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the striping rules.
  task automatic model(input bit rn, input bit v, input longint eva,
                       input longint px, input longint py);
    longint b, bank, xs, row, layer, ypod, ys;
    if (!rn) begin
      m_v = 0; m_x = 0; m_y = 0; m_epa = 0;
      return;
    end
    m_v = v;
    if (!v) return;
    b     = (eva % (64'd1 << 31)) / (4 * c_blk);
    bank  = b % (c_nx * 2 * c_rows);
    xs    = bank % c_nx;
    row   = bank / c_nx;
    layer = row / 2;
    if (row % 2 == 0) begin
      ypod = (py + 15) % 16;
      ys   = c_rows - 1 - layer;
    end else begin
      ypod = (py + 1) % 16;
      ys   = layer;
    end
    m_x   = px * c_nx + xs;
    m_y   = ypod * 8 + ys;
    m_epa = ((b / (c_nx * 2 * c_rows)) * c_blk + (eva / 4) % c_blk) % (64'd1 << 28);
  endtask

  task automatic step(input bit rn, input bit v, input logic [31:0] eva,
                      input logic [2:0] px, input logic [3:0] py);
    reset_n_i = rn; v_i = v; eva_i = eva; pod_x_i = px; pod_y_i = py;
    @(posedge clk);
    #1;
    model(rn, v, longint'(eva), longint'(px), longint'(py));
    check_val("v_o",   longint'(v_o),      m_v);
    check_val("x_cord", longint'(x_cord_o), m_x);
    check_val("y_cord", longint'(y_cord_o), m_y);
    check_val("epa",   longint'(epa_o),    m_epa);
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b1; eva_i = 32'h8000_0020; pod_x_i = 3'd1; pod_y_i = 4'd1;
    m_v = 0; m_x = 0; m_y = 0; m_epa = 0;

    // Reset overrides v_i
    step(1'b0, 1'b1, 32'h8000_0020, 3'd1, 4'd1);
    check_val("rst_v",   longint'(v_o), 0);
    check_val("rst_x",   longint'(x_cord_o), 0);
    check_val("rst_epa", longint'(epa_o), 0);

    // First DRAM address after release
    step(1'b1, 1'b1, 32'h8000_0000, 3'd1, 4'd1);
    check_val("b0_v", longint'(v_o), 1);
    check_val("b0_x", longint'(x_cord_o), 'h10);
    check_val("b0_y", longint'(y_cord_o), 'h00);

    step(1'b1, 1'b1, 32'h8000_0020, 3'd1, 4'd1);
    check_val("b1_x", longint'(x_cord_o), 'h11);
    step(1'b1, 1'b1, 32'h8000_001C, 3'd1, 4'd1);
    check_val("w7_epa", longint'(epa_o), 7);
    check_val("w7_x",   longint'(x_cord_o), 'h10);

    // Row 1 -> south pod
    step(1'b1, 1'b1, 32'h8000_0200, 3'd1, 4'd1);
    check_val("south_y", longint'(y_cord_o), 'h10);
    check_val("south_epa", longint'(epa_o), 0);
    step(1'b1, 1'b1, 32'h8000_0400, 3'd1, 4'd1);
    check_val("b32_y",   longint'(y_cord_o), 'h00);
    check_val("b32_epa", longint'(epa_o), 8);

    // North pod wraps below pod 0
    step(1'b1, 1'b1, 32'h8000_0000, 3'd1, 4'd0);
    check_val("wrap_y", longint'(y_cord_o), 'h78);
    // South pod wraps above pod 15
    step(1'b1, 1'b1, 32'h8000_0200, 3'd1, 4'd15);
    check_val("wrap_s_y", longint'(y_cord_o), 'h00);

    // Invalid cycle: hold fields, drop valid
    step(1'b1, 1'b0, 32'h8000_0020, 3'd5, 4'd7);
    check_val("hold_v", longint'(v_o), 0);
    check_val("hold_y", longint'(y_cord_o), 'h00);

    // Bit 31 clear is hashed like a DRAM address
    step(1'b1, 1'b1, 32'h0000_1000, 3'd1, 4'd1);
    check_val("nodram_x",   longint'(x_cord_o), 'h10);
    check_val("nodram_epa", longint'(epa_o), 'h20);

    // Top of the EVA space
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 3'd7, 4'd3);
    check_val("max_x",   longint'(x_cord_o), 'h7F);
    check_val("max_epa", longint'(epa_o), 'hFF_FFFF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           32'($urandom), 3'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
